mem_arbiter: RTL

Single-port 128x16 memory with a two-requester arbiter. It shares the program/data store between the CPU fetch/operand path (port A) and a loader/debug path (port B) that preloads programs and inspects results. One access completes every three cycles. Contention is resolved round-robin, and out-of-range addresses are flagged.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port word memory shared by two requesters with round-robin arbitration
module mem_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          last_grant,
  output logic          err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    r_state;
  logic          r_winner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_err;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic          r_busy;
  logic          r_last_grant;
  logic          r_err_o;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_grant_b;
  logic          w_oob;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_rd;

  // B wins when it is the only requester, or on contention when A was served last
  assign w_grant_b = b_req & (~a_req | ~r_last_grant);
  assign w_oob     = int'(r_addr) >= DEPTH;
  assign w_idx     = r_addr[IW-1:0];
  assign w_rd      = w_oob ? '0 : r_mem[w_idx];

  // Array is deliberately not reset; its image is loaded through port B
  always_ff @(posedge Clk) begin
    if (!Reset && r_state == S_ACCESS && r_we && !w_oob) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_winner     <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
      r_err_o      <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (a_req || b_req) begin
            r_winner <= w_grant_b;
            r_we     <= w_grant_b ? b_we    : a_we;
            r_addr   <= w_grant_b ? b_addr  : a_addr;
            r_wdata  <= w_grant_b ? b_wdata : a_wdata;
            r_state  <= S_ACCESS;
            r_busy   <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_err <= w_oob;
          if (!r_we) begin
            if (r_winner) r_b_rdata <= w_rd;
            else          r_a_rdata <= w_rd;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_a_ack      <= ~r_winner;
          r_b_ack      <= r_winner;
          r_err_o      <= r_err;
          r_last_grant <= r_winner;
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack      = r_a_ack;
  assign b_ack      = r_b_ack;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;
  assign err        = r_err_o;

endmodule
